// File: rtl/lr35902_vram_dma.sv
// Block-oriented VRAM DMA: copies BLOCK_BYTES-sized blocks from the CPU bus into VRAM,
// as one stalled burst or (with VRAM_DMA_HBLANK_MODE_EN defined) one block per H-blank.
module lr35902_vram_dma #(
  parameter int CYCLES_PER_BYTE = 4,
  parameter int BLOCK_BYTES     = 16,
  parameter int LEN_BITS        = 7,
  parameter int DST_BITS        = 13
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [2:0]          reg_adr,
  input  logic [7:0]          reg_din,
  input  logic                reg_write,
  output logic [7:0]          reg_dout,
  input  logic                hblank,
  output logic [15:0]         adr,
  input  logic [7:0]          din,
  output logic                read,
  output logic [DST_BITS-1:0] adr_vram,
  output logic [7:0]          dout,
  output logic                write,
  output logic                active
);

  localparam int OFS_BITS = $clog2(BLOCK_BYTES);
  localparam int CYC_BITS = $clog2(CYCLES_PER_BYTE);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_COPY, S_HWAIT} state_t;

  state_t               state, state_next;
  logic                 wr_q;
  logic [2:0]           radr_q;
  logic [7:0]           rdin_q;
  logic [7:0]           src_hi, src_lo, dst_hi, dst_lo;
  logic [15:0]          src_cnt;
  logic [DST_BITS-1:0]  dst_cnt;
  logic [LEN_BITS-1:0]  remaining;
  logic [CYC_BITS-1:0]  cyc;
  logic [OFS_BITS-1:0]  idx;

  logic        commit, ctrl_commit, start, start_hdma, cancel_req;
  logic        cyc_last, block_end;
  logic        hdma, cancel, hstart;
  logic [15:0] src_base;
  logic [DST_BITS-1:0] dst_base;

  // A register write lands on the falling edge of the strobe, so a long strobe commits once.
  assign commit      = wr_q & ~reg_write;
  assign ctrl_commit = commit && (radr_q == 3'd4);
  assign start       = ctrl_commit && (state == S_IDLE);
  assign cyc_last    = (cyc == CYC_BITS'(CYCLES_PER_BYTE - 1));
  assign block_end   = (state == S_COPY) && cyc_last && (idx == '1);
  assign cancel_req  = ctrl_commit && hdma && !rdin_q[7] && (state != S_IDLE);

  assign src_base = {src_hi, src_lo} & ~16'(BLOCK_BYTES - 1);
  assign dst_base = DST_BITS'({dst_hi, dst_lo}) & ~DST_BITS'(BLOCK_BYTES - 1);

`ifdef VRAM_DMA_HBLANK_MODE_EN
  logic hblank_q, kick;

  always_ff @(posedge clk) begin
    if (reset) begin
      hdma     <= 1'b0;
      cancel   <= 1'b0;
      kick     <= 1'b0;
      hblank_q <= 1'b0;
    end else begin
      hblank_q <= hblank;
      if (start) begin
        hdma   <= rdin_q[7];
        // An H-blank already in progress at commit time serves the first block.
        kick   <= rdin_q[7] & hblank;
        cancel <= 1'b0;
      end else begin
        if (state == S_HWAIT && hstart) kick <= 1'b0;
        if (state_next == S_IDLE)       cancel <= 1'b0;
        else if (cancel_req)            cancel <= 1'b1;
      end
    end
  end

  assign hstart     = kick | (hblank & ~hblank_q);
  assign start_hdma = start & rdin_q[7];
`else
  logic unused_hblank;
  assign unused_hblank = hblank;
  assign hdma          = 1'b0;
  assign cancel        = 1'b0;
  assign hstart        = 1'b0;
  assign start_hdma    = 1'b0;
`endif

  // NOTE: every output of an always_comb gets a default first, otherwise paths that skip
  // an assignment make the tool infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = start_hdma ? S_HWAIT : S_SETUP;
      S_SETUP: if (cyc_last) state_next = S_COPY;
      S_COPY: begin
        if (block_end) begin
          if (remaining == '0 || cancel || cancel_req) state_next = S_IDLE;
          else if (hdma)                               state_next = S_HWAIT;
        end
      end
`ifdef VRAM_DMA_HBLANK_MODE_EN
      S_HWAIT: begin
        if (cancel_req)  state_next = S_IDLE;
        else if (hstart) state_next = S_SETUP;
      end
`endif
      default: state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      wr_q      <= 1'b0;
      remaining <= '1;
      cyc       <= '0;
      idx       <= '0;
    end else begin
      state <= state_next;
      wr_q  <= reg_write;
      if (start)          remaining <= rdin_q[LEN_BITS-1:0];
      else if (block_end) remaining <= remaining - LEN_BITS'(1);
      if (state == S_SETUP || state == S_COPY) cyc <= cyc_last ? '0 : cyc + CYC_BITS'(1);
      else                                     cyc <= '0;
      if (state == S_COPY && cyc_last) idx <= idx + OFS_BITS'(1);
      else if (state == S_IDLE)        idx <= '0;
    end
  end

  // NOTE: address and strobe-capture registers carry no reset; they are always written
  // before being used, and the control path above guards every use.
  always_ff @(posedge clk) begin
    if (reg_write) begin
      radr_q <= reg_adr;
      rdin_q <= reg_din;
    end
    if (commit && state == S_IDLE) begin
      case (radr_q)
        3'd0:    src_hi <= rdin_q;
        3'd1:    src_lo <= rdin_q;
        3'd2:    dst_hi <= rdin_q;
        3'd3:    dst_lo <= rdin_q;
        default: ;
      endcase
    end
    if (start) begin
      src_cnt <= src_base;
      dst_cnt <= dst_base;
    end else if (state == S_COPY && cyc_last) begin
      src_cnt <= src_cnt + 16'd1;
      dst_cnt <= dst_cnt + DST_BITS'(1);
    end
  end

  assign active   = (state == S_SETUP) || (state == S_COPY);
  assign read     = (state == S_COPY) && ((cyc >> 1) == '0);
  assign write    = read;
  assign adr      = src_cnt;
  assign adr_vram = dst_cnt;
  assign dout     = din;
  assign reg_dout = {state == S_IDLE, 7'(remaining)};

endmodule

// File: doc/lr35902_vram_dma.md
Name: lr35902_vram_dma

Overview:
- Parametrised general DMA engine; successor to the fixed 160-byte OAM copier.
- Copies blocks from the CPU address space into VRAM in one of two modes:
  - general (one burst, CPU stalled);
  - H-blank (one block per H-blank).
- Programmed through five byte registers (SRC_HI, SRC_LO, DST_HI, DST_LO, CTRL).
- Sits beside the OAM DMA in the PPU: bus mux on the source side, VRAM port on the destination side.

Parameters:
- CYCLES_PER_BYTE, 4, clocks per transferred byte (min 2).
- BLOCK_BYTES, 16, bytes per block (power of 2, 2..128).
- LEN_BITS, 7, width of block-count field; max transfer = 2^LEN_BITS blocks.
- DST_BITS, 13, VRAM destination address width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- reg_adr  in  3  register select: 0 SRC_HI, 1 SRC_LO, 2 DST_HI, 3 DST_LO, 4 CTRL.
- reg_din  in  8  register write data.
- reg_write  in  1  write strobe (multi-cycle allowed).
- reg_dout  out  8  CTRL readback.
- hblank  in  1  PPU H-blank level.
- adr  out  16  source address.
- din  in  8  source data.
- read  out  1  source read strobe.
- adr_vram  out  DST_BITS  destination address.
- dout  out  8  destination data (= din).
- write  out  1  destination write strobe.
- active  out  1  CPU stall request; high while a block is being copied.

Behaviour:
- Register writes commit on the first clock where reg_write falls (registered high, now low), using the reg_adr/reg_din registered on the last strobe cycle.
- Address/length formatting:
  - Source: low log2(BLOCK_BYTES) bits are forced to 0.
  - Destination: top bits above DST_BITS are dropped; low log2(BLOCK_BYTES) bits are forced to 0.
  - Length = CTRL[LEN_BITS-1:0]; blocks = len+1.
- States: IDLE, SETUP, COPY, HWAIT.
- CTRL commit with bit7=0 while IDLE:
  - Go to SETUP with mode=GDMA.
  - SETUP lasts CYCLES_PER_BYTE clocks, then COPY.
  - active rises on the first SETUP clock.
- CTRL commit with bit7=1 while IDLE:
  - Go to HWAIT with mode=HDMA.
  - If hblank is already high at commit, the first block starts at that H-blank.
- HWAIT:
  - A registered rising edge of hblank (or the level condition above) moves to SETUP.
  - active stays 0 in HWAIT.
- COPY: per byte, a cycle counter runs 0..CYCLES_PER_BYTE-1.
  - read and write are high only while counter < 2.
  - Source and destination increment together after the last counter cycle.
- End of block (byte index = BLOCK_BYTES-1 completes):
  - Remaining count decrements.
  - If the count was 0: go to IDLE.
  - Else, GDMA continues in COPY; HDMA goes to HWAIT and drops active.
- The destination counter wraps modulo 2^DST_BITS. The source counter wraps modulo 2^16. Neither wrap ends the transfer.
- CTRL commit with bit7=0 during HDMA (HWAIT or mid-block):
  - The current block finishes, then the engine goes to IDLE.
  - remaining keeps its value.
- A CTRL commit during GDMA is ignored. SRC/DST writes while not IDLE are ignored.
- Readback (reg_dout):
  - IDLE: {1, remaining}, with remaining = all-ones after normal completion.
  - Busy: {0, remaining}.
- Reset, including mid-transfer:
  - State IDLE.
  - active=0, read=0, write=0.
  - remaining all-ones; reg_dout = 8'hFF.
  - Strobe history cleared.
  - Address registers undefined.

Optional Feature:
- Macro: VRAM_DMA_HBLANK_MODE_EN.
- Defined: behaviour as above.
- Undefined:
  - CTRL bit7 is ignored; every transfer is GDMA.
  - HWAIT is absent; the hblank input is unused.
  - Readback bit7 is 1 whenever IDLE, 0 when busy.

Test Plan:
- GDMA, defaults: SRC=16'hC00F, DST=16'h9FF3, CTRL=8'h01 → 32 bytes copied, source C000..C01F to VRAM 1FF0..1FFF then 0000..000F (wrap). active high for exactly 4+32*4 = 132 clocks from the first SETUP clock; then reg_dout=8'hFF.
- HDMA, CTRL=8'h82: 3 blocks of 16 bytes, one per hblank rising edge. active pulses 4+64 clocks each. reg_dout reads 8'h02, 8'h01, 8'h00 while waiting, then 8'hFF.
- HDMA cancel: CTRL=8'h83, then CTRL=8'h00 mid-block 1 → block 1 completes (16 writes). No further writes on later hblanks. reg_dout = 8'h82.
- Reset at byte 5 of GDMA → next clock active=0, read=0, write=0, reg_dout=8'hFF. No writes after reset.
- Slow strobe: reg_write held 3 clocks with CTRL=8'h00 → exactly one transfer starts, on the clock after the strobe falls. A CTRL write during GDMA has no effect.
- Macro undefined: CTRL=8'h80 → immediate 16-byte GDMA independent of hblank.
